// File: rtl/serv_dbg_inject.sv
// Debug instruction injector: answers core ibus fetches in debug mode with
// RISC-V words (GPR read/write via dscratch0, dret, ebreak) built from abstract commands.
module serv_dbg_inject #(
    parameter logic [11:0] DSCRATCH_ADR = 12'h7b2
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_dbg_mode,
    output logic        o_sel,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [1:0]  i_cmd_op,
    input  logic [4:0]  i_cmd_regno,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    output logic        o_done,
    output logic        o_busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_XFER   = 3'd1;
    localparam logic [2:0] ST_RETIRE = 3'd2;
    localparam logic [2:0] ST_RESUME = 3'd3;
    localparam logic [2:0] ST_STEP   = 3'd4;

    localparam logic [31:0] WORD_NOP    = 32'h0000_0013;
    localparam logic [31:0] WORD_DRET   = 32'h7B20_0073;
    localparam logic [31:0] WORD_EBREAK = 32'h0010_0073;

    logic [2:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  regno_q, regno_d;
    logic [31:0] rdt_q, rdt_d;
    logic        ack_q, ack_d;
    logic        done_q, done_d;
    logic        seen_low_q, seen_low_d;

    logic [31:0] word;
    logic        fetch;

    always_comb begin
        case (op_q)
            2'd0:    word = {DSCRATCH_ADR, regno_q, 3'b001, 5'd0, 7'h73};
            2'd1:    word = {DSCRATCH_ADR, 5'd0, 3'b010, regno_q, 7'h73};
            2'd2:    word = WORD_DRET;
            default: word = WORD_EBREAK;
        endcase
    end

    // A fetch still held in the ack cycle is the one just answered, not a new one.
    assign fetch = i_ibus_cyc & ~ack_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        regno_d    = regno_q;
        rdt_d      = rdt_q;
        ack_d      = 1'b0;
        done_d     = 1'b0;
        seen_low_d = seen_low_q;

        if (!i_dbg_mode) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        op_d       = i_cmd_op;
                        regno_d    = i_cmd_regno;
                        seen_low_d = 1'b0;
                        case (i_cmd_op)
                            2'd0, 2'd1: state_d = ST_XFER;
                            2'd2:       state_d = ST_RESUME;
                            default:    state_d = ST_STEP;
                        endcase
                    end
                end
                ST_XFER: begin
                    if (fetch) begin
                        ack_d   = 1'b1;
                        rdt_d   = word;
                        state_d = ST_RETIRE;
                    end
                end
                // The core's following fetch proves the injected word retired.
                ST_RETIRE: begin
                    if (!i_ibus_cyc) begin
                        seen_low_d = 1'b1;
                    end else if (seen_low_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_RESUME, ST_STEP: begin
                    if (fetch) begin
                        ack_d   = 1'b1;
                        done_d  = 1'b1;
                        rdt_d   = word;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            regno_q    <= '0;
            rdt_q      <= WORD_NOP;
            ack_q      <= 1'b0;
            done_q     <= 1'b0;
            seen_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            regno_q    <= regno_d;
            rdt_q      <= rdt_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            seen_low_q <= seen_low_d;
        end
    end

    assign o_sel       = i_dbg_mode;
    assign o_cmd_ready = (state_q == ST_IDLE) & i_dbg_mode;
    assign o_ibus_rdt  = rdt_q;
    assign o_ibus_ack  = ack_q;
    assign o_done      = done_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serv_dbg_inject.sv
// Bench for serv_dbg_inject: transaction-level model checked every cycle,
// directed scenarios with literal words, then randomized traffic.
module tb_serv_dbg_inject;

    logic        clk;
    logic        rst;
    logic        dbg;
    logic        sel;
    logic        cvalid;
    logic        cready;
    logic [1:0]  cop;
    logic [4:0]  creg;
    logic        cyc;
    logic [31:0] rdt;
    logic        ack;
    logic        done;
    logic        busy;

    serv_dbg_inject #(.DSCRATCH_ADR(12'h7b2)) dut (
        .clk         (clk),
        .i_rst       (rst),
        .i_dbg_mode  (dbg),
        .o_sel       (sel),
        .i_cmd_valid (cvalid),
        .o_cmd_ready (cready),
        .i_cmd_op    (cop),
        .i_cmd_regno (creg),
        .i_ibus_cyc  (cyc),
        .o_ibus_rdt  (rdt),
        .o_ibus_ack  (ack),
        .o_done      (done),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: one outstanding debug job described by what it still needs.
    logic        m_job;
    logic [31:0] m_word;
    logic        m_fin_on_ack;
    logic        m_acked;
    logic        m_saw_low;
    logic        e_ack, e_done;
    logic [31:0] e_rdt;

    logic        chk_en    = 1'b0;
    logic        chk_nop   = 1'b0;
    logic        lit_valid = 1'b0;
    logic [31:0] lit_word  = '0;
    int          tmo       = 0;
    int          tmo_seen  = 0;

    function automatic logic [31:0] enc(input logic [1:0] op, input logic [4:0] r);
        logic [31:0] rr;
        rr = {27'd0, r};
        case (op)
            2'd0:    return 32'h7B201073 | (rr << 15);
            2'd1:    return 32'h7B202073 | (rr << 7);
            2'd2:    return 32'h7B200073;
            default: return 32'h00100073;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic n_ack, n_done;
        n_ack  = 1'b0;
        n_done = 1'b0;
        if (rst) begin
            m_job = 1'b0;
            e_rdt = 32'h13;
        end else if (m_job && !dbg) begin
            m_job = 1'b0;
        end else if (m_job) begin
            if (!m_acked) begin
                if (cyc && !e_ack) begin
                    n_ack   = 1'b1;
                    e_rdt   = m_word;
                    m_acked = 1'b1;
                    if (m_fin_on_ack) begin
                        n_done = 1'b1;
                        m_job  = 1'b0;
                    end
                end
            end else if (!cyc) begin
                m_saw_low = 1'b1;
            end else if (m_saw_low) begin
                n_done = 1'b1;
                m_job  = 1'b0;
            end
        end else if (dbg && cvalid) begin
            m_job        = 1'b1;
            m_word       = enc(cop, creg);
            m_fin_on_ack = (cop >= 2'd2);
            m_acked      = 1'b0;
            m_saw_low    = 1'b0;
        end
        e_ack  = n_ack;
        e_done = n_done;
        #1;
        if (chk_en) begin
            chk("ack",   {31'd0, ack},    {31'd0, e_ack});
            chk("done",  {31'd0, done},   {31'd0, e_done});
            chk("rdt",   rdt,             e_rdt);
            chk("busy",  {31'd0, busy},   {31'd0, m_job});
            chk("ready", {31'd0, cready}, {31'd0, (!m_job && dbg)});
            chk("sel",   {31'd0, sel},    {31'd0, dbg});
            if (lit_valid && ack) begin
                chk("lit_rdt",   rdt,   lit_word);
                chk("lit_model", e_rdt, lit_word);
            end
            if (chk_nop) chk("nop_rdt", rdt, 32'h13);
            if (tmo != tmo_seen) begin
                chk("timeout", tmo_seen, tmo);
                tmo_seen = tmo;
            end
        end
    end

    logic core_auto = 1'b0;
    int   gap       = 0;

    // Advance to the next falling edge, then let the modelled core react to ack.
    task automatic tick();
        @(negedge clk);
        if (core_auto) begin
            if (ack) begin
                cyc = 1'b0;
                gap = $urandom_range(1, 3);
            end else if (!cyc) begin
                if (gap > 0) gap--;
                if (gap == 0) cyc = 1'b1;
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] r, input logic [31:0] lit);
        lit_word  = lit;
        lit_valid = 1'b1;
        cop       = op;
        creg      = r;
        cvalid    = 1'b1;
        tick();
        cvalid    = 1'b0;
    endtask

    initial begin
        bit got;
        rst = 1'b1; dbg = 1'b1; cvalid = 1'b0; cop = '0; creg = '0; cyc = 1'b0;
        ticks(3);
        rst = 1'b0; chk_en = 1'b1; chk_nop = 1'b1;
        tick();
        chk_nop = 1'b0;

        // Read x5, write x10, resume, each with a cooperating core.
        core_auto = 1'b1; cyc = 1'b1;
        issue(2'd0, 5'd5, 32'h7B229073);
        ticks(15);
        issue(2'd1, 5'd10, 32'h7B202573);
        ticks(15);
        issue(2'd2, 5'd0, 32'h7B200073);
        ticks(6);
        dbg = 1'b0;
        ticks(5);

        // Parked fetch with no command, then step-ebreak.
        dbg = 1'b1; core_auto = 1'b0; cyc = 1'b1; lit_valid = 1'b0;
        ticks(20);
        core_auto = 1'b1;
        issue(2'd3, 5'd0, 32'h00100073);
        ticks(8);

        // Reset while waiting for the retire fetch.
        issue(2'd0, 5'd17, 32'h7B289073);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (ack) got = 1'b1; else tick();
        end
        if (!got) tmo++;
        rst = 1'b1;
        tick();
        rst = 1'b0; chk_nop = 1'b1;
        tick();
        chk_nop = 1'b0;
        ticks(4);

        // Debug mode dropped in XFER before any fetch.
        core_auto = 1'b0; cyc = 1'b0;
        issue(2'd0, 5'd0, 32'h7B201073);
        dbg = 1'b0;
        tick();
        cyc = 1'b1; cvalid = 1'b1;
        ticks(4);
        cvalid = 1'b0; dbg = 1'b1;
        ticks(4);

        // Randomized traffic.
        lit_valid = 1'b0; core_auto = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 99) == 0);
            dbg    = ($urandom_range(0, 39) != 0);
            cvalid = ($urandom_range(0, 2) == 0);
            cop    = 2'($urandom);
            creg   = 5'($urandom);
            tick();
        end
        rst = 1'b0; cvalid = 1'b0;
        ticks(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
